// File: rtl/fuse_key_loader.sv
// fuse_key_loader
// Boot-time sequencer that walks fuse indices 0..NUM_KEYS-1. For each index it
// asks the peripheral key table (pkt) for the destination address, reads the
// fuse word in the same cycle, and then issues one 32-bit write on a
// valid/ready channel. An index for which pkt reports the out-of-range
// location is skipped and counted. A write that is not accepted within
// WR_TIMEOUT cycles is dropped and flagged.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                pulse that begins a sequence (ignored while busy)
//   busy_o                 high from the cycle after an accepted start until done_o
//   done_o                 one-cycle completion pulse
//   err_o                  sticky error (skip or write timeout), cleared on start
//   skip_cnt_o[15:0]       saturating count of skipped indices, cleared on start
//   pkt_req_o              pkt lookup strobe
//   pkt_indx_o[31:0]       pkt lookup index (zero-extended current index)
//   pkey_loc_i[63:0]       pkt lookup result, valid the cycle after pkt_req_o
//   fuse_req_o             fuse read strobe
//   fuse_addr_o[31:0]      fuse word index (same as pkt_indx_o)
//   fuse_rdata_i[31:0]     fuse read data, valid the cycle after fuse_req_o
//   wr_valid_o             write request
//   wr_addr_o[63:0]        write address (captured pkt location)
//   wr_data_o[31:0]        write data (captured fuse word)
//   wr_ready_i             write accepted when high together with wr_valid_o
`timescale 1ns/1ps

module fuse_key_loader #(
  parameter int unsigned NUM_KEYS   = 100,
  parameter int unsigned WR_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] skip_cnt_o,
  output logic        pkt_req_o,
  output logic [31:0] pkt_indx_o,
  input  logic [63:0] pkey_loc_i,
  output logic        fuse_req_o,
  output logic [31:0] fuse_addr_o,
  input  logic [31:0] fuse_rdata_i,
  output logic        wr_valid_o,
  output logic [63:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  input  logic        wr_ready_i
);

  // pkt answers with this location for an index it does not know.
  localparam logic [63:0] LOC_INVALID = 64'h0000_0000_FFFF_FFFF;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_KEYS - 1);
  // The timeout counter starts at 0 in the first WRITE cycle, so the last
  // permitted cycle is the one where it equals WR_TIMEOUT-1.
  localparam logic [15:0] TMO_LAST    = 16'(WR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] skip_q, skip_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        advance;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    skip_d     = skip_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    advance    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    pkt_req_o  = 1'b0;
    fuse_req_o = 1'b0;
    wr_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          idx_d   = '0;
          err_d   = 1'b0;
          skip_d  = '0;
        end
      end
      S_REQ: begin
        busy_o     = 1'b1;
        pkt_req_o  = 1'b1;
        fuse_req_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        addr_d = pkey_loc_i;
        data_d = fuse_rdata_i;
        if (pkey_loc_i == LOC_INVALID) begin
          err_d   = 1'b1;
          skip_d  = sat_inc16(skip_q);
          advance = 1'b1;
        end else begin
          tmo_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o     = 1'b1;
        wr_valid_o = 1'b1;
        if (wr_ready_i) begin
          advance = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          // Key is dropped, never retried; only err_o records the loss.
          err_d   = 1'b1;
          advance = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 16'd1;
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      tmo_q  <= '0;
      skip_q <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      tmo_q  <= tmo_d;
      skip_q <= skip_d;
      err_q  <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign err_o       = err_q;
  assign skip_cnt_o  = skip_q;
  assign pkt_indx_o  = {16'h0000, idx_q};
  assign fuse_addr_o = {16'h0000, idx_q};
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;

endmodule

// File: tb/tb_fuse_key_loader.sv
`timescale 1ns/1ps

module tb_fuse_key_loader;

  typedef struct {
    int   stall_idx;
    int   stall_len;
    int   bad_idx;
    int   exp_done;
    int   exp_first;
    int   exp_writes;
    int   exp_vcyc;
    logic exp_err;
    int   exp_skip;
  } vec_t;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  // main instance (NUM_KEYS=4)
  logic        start, busy, done, err;
  logic [15:0] skip;
  logic        pkt_req, fuse_req, wr_valid, rdy;
  logic [31:0] pkt_indx, fuse_addr, fuse_rdata, wr_data;
  logic [63:0] pkey_loc, wr_addr;
  // timeout instance (NUM_KEYS=2, WR_TIMEOUT=8, never ready)
  logic        start2, busy2, done2, err2;
  logic [15:0] skip2;
  logic        preq2, freq2, wv2;
  logic        rdy2;
  logic [31:0] pidx2, faddr2, fdata2, wd2;
  logic [63:0] ploc2, wa2;

  int cyc = 0;
  int stall_idx, stall_len, bad_idx;
  int stall_cnt;
  int nchk = 0, nerr = 0;
  int t0, t2, hs, vc, rq, fv, done_cyc, v2, d2;
  logic seen_done, seen2;
  logic prev_valid, prev_hs;
  logic [63:0] prev_addr;
  logic [31:0] prev_data;
  wr_t exp_q[$];
  vec_t vec[5];

  fuse_key_loader #(.NUM_KEYS(4), .WR_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .skip_cnt_o(skip), .pkt_req_o(pkt_req), .pkt_indx_o(pkt_indx),
    .pkey_loc_i(pkey_loc), .fuse_req_o(fuse_req), .fuse_addr_o(fuse_addr),
    .fuse_rdata_i(fuse_rdata), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .wr_ready_i(rdy)
  );

  fuse_key_loader #(.NUM_KEYS(2), .WR_TIMEOUT(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .skip_cnt_o(skip2), .pkt_req_o(preq2), .pkt_indx_o(pidx2),
    .pkey_loc_i(ploc2), .fuse_req_o(freq2), .fuse_addr_o(faddr2),
    .fuse_rdata_i(fdata2), .wr_valid_o(wv2), .wr_addr_o(wa2),
    .wr_data_o(wd2), .wr_ready_i(rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pkt and fuse models: one-cycle registered response
  always @(posedge clk) begin
    if (pkt_req)
      pkey_loc <= (bad_idx >= 0 && pkt_indx == 32'(bad_idx)) ? 64'h0000_0000_FFFF_FFFF
                                                              : 64'(32'h1000 + 32'd4 * pkt_indx);
    if (fuse_req) fuse_rdata <= 32'hA0 + fuse_addr;
    if (preq2) ploc2 <= 64'(32'h2000 + 32'd4 * pidx2);
    if (freq2) fdata2 <= 32'h50 + faddr2;
  end

  // write-ready stall generator
  assign rdy  = !(stall_len > 0 && pkt_indx == 32'(stall_idx) && stall_cnt < stall_len);
  assign rdy2 = 1'b0;
  always @(posedge clk) begin
    if (start && !busy) stall_cnt <= 0;
    else if (wr_valid && !rdy) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    if (start && !busy) begin
      hs = 0; vc = 0; rq = 0; fv = -1; seen_done = 1'b0;
    end
    if (start2 && !busy2) begin
      v2 = 0; seen2 = 1'b0;
    end
    if (pkt_req) begin
      chk("req_index", 64'(pkt_indx), 64'(rq));
      chk("fuse_addr", 64'(fuse_addr), 64'(pkt_indx));
      chk("fuse_req", 64'(fuse_req), 64'd1);
      rq++;
    end
    if (wr_valid) begin
      vc++;
      if (fv < 0) fv = cyc - t0;
      if (prev_valid && !prev_hs) begin
        chk("hold_addr", wr_addr, prev_addr);
        chk("hold_data", 64'(wr_data), 64'(prev_data));
      end
      if (rdy) begin
        hs++;
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", 64'(wr_data), 64'(e.d));
        end
      end
    end
    prev_valid = wr_valid;
    prev_hs    = wr_valid && rdy;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    if (done) begin
      seen_done = 1'b1; done_cyc = cyc - t0;
    end
    if (wv2) v2++;
    if (done2) begin
      seen2 = 1'b1; d2 = cyc - t2;
    end
  endtask

  // Sample mid-cycle, return just after the next rising edge for driving.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    for (int n = 0; n < 200 && !seen_done; n++) tick();
    if (!seen_done) begin
      nchk++; nerr++;
      $display("FAIL %s_done_timeout: got no done_o, expected done_o within 200 cycles", nm);
    end
  endtask

  task automatic push_exp(input int bad);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      if (i != bad) begin
        e.a = 64'(4096 + 4 * i);
        e.d = 32'(160 + i);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_row(input vec_t v, input int r);
    string nm;
    nm = $sformatf("row%0d", r);
    stall_idx = v.stall_idx;
    stall_len = v.stall_len;
    bad_idx   = v.bad_idx;
    push_exp(v.bad_idx);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_done(nm);
    chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    chk({nm, "_first_valid"}, 64'(fv), 64'(v.exp_first));
    chk({nm, "_writes"}, 64'(hs), 64'(v.exp_writes));
    chk({nm, "_valid_cycles"}, 64'(vc), 64'(v.exp_vcyc));
    chk({nm, "_pkt_reqs"}, 64'(rq), 64'd4);
    chk({nm, "_err"}, 64'(err), 64'(v.exp_err));
    chk({nm, "_skip"}, 64'(skip), 64'(v.exp_skip));
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    stall_idx = 0; stall_len = 0; bad_idx = -1;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_addr = '0; prev_data = '0;
    hs = 0; vc = 0; rq = 0; fv = -1; done_cyc = 0; v2 = 0; d2 = 0; t0 = 0; t2 = 0;
    seen_done = 1'b0; seen2 = 1'b0;

    //           stall_idx len bad done first wr vcyc err skip
    vec[0] = '{0, 0, -1, 13, 3, 4, 4, 1'b0, 0};
    vec[1] = '{1, 5, -1, 18, 3, 4, 9, 1'b0, 0};
    vec[2] = '{0, 0,  2, 12, 3, 3, 3, 1'b1, 1};
    vec[3] = '{0, 0, -1, 13, 3, 4, 4, 1'b0, 0};
    vec[4] = '{3, 2,  0, 14, 5, 3, 5, 1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_skip", 64'(skip), 64'd0);
    chk("rst_pkt_req", 64'(pkt_req), 64'd0);
    chk("rst_pkt_indx", 64'(pkt_indx), 64'd0);
    chk("rst_fuse_req", 64'(fuse_req), 64'd0);
    chk("rst_fuse_addr", 64'(fuse_addr), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // table rows run back to back: each start follows the previous done_o
    for (int r = 0; r < 5; r++) run_row(vec[r], r);

    // start_i pulsed while busy must be ignored
    stall_len = 0; stall_idx = 0; bad_idx = -1;
    push_exp(-1);
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("busy_start");
    chk("busy_start_done_cycle", 64'(done_cyc), 64'd13);
    chk("busy_start_writes", 64'(hs), 64'd4);
    chk("busy_start_queue_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_start_no_restart", 64'(busy), 64'd0);
    end

    // asynchronous reset while a write is pending
    push_exp(-1);
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    for (int n = 0; n < 20 && !wr_valid; n++) tick();
    chk("midrst_in_write", 64'(wr_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
    chk("midrst_wr_addr", wr_addr, 64'd0);
    chk("midrst_wr_data", 64'(wr_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pkt_indx", 64'(pkt_indx), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    run_row(vec[0], 9);

    // write timeout instance
    start2 = 1'b1; t2 = cyc; tick(); start2 = 1'b0;
    for (int n = 0; n < 100 && !seen2; n++) tick();
    chk("tmo_done_seen", 64'(seen2), 64'd1);
    chk("tmo_done_cycle", 64'(d2), 64'd21);
    chk("tmo_valid_cycles", 64'(v2), 64'd16);
    chk("tmo_err", 64'(err2), 64'd1);
    chk("tmo_skip", 64'(skip2), 64'd0);
    chk("tmo_valid_dropped", 64'(wv2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fuse_key_loader.md
# fuse_key_loader

Boot-time sequencer that pushes every fuse-resident key and policy word to its peripheral destination. It walks fuse indices 0..NUM_KEYS-1. For each index it looks up the destination address in the peripheral key table (pkt) and reads the fuse word. It then issues one 32-bit write on a valid/ready write channel into the key/ACCT register space. It is the initiator on the pkt `req_i`/`fuse_indx_i`/`pkey_loc_o` interface and sits between the fuse memory, pkt and the AXI-lite write adapter.

## Interface
Parameters:
- `NUM_KEYS`, default 100: number of fuse indices walked. Must match pkt `FUSE_MEM_SIZE`. Range 1..65535.
- `WR_TIMEOUT`, default 255: maximum cycles the block waits for `wr_ready_i` per write. Range 1..65535.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse that begins a load sequence. Ignored while `busy_o`=1.
- `busy_o`  out  1  high from the cycle after an accepted `start_i` until `done_o`, inclusive.
- `done_o`  out  1  one-cycle pulse when the sequence finishes.
- `err_o`  out  1  sticky; set by a skip or a timeout; cleared on accepted `start_i`.
- `skip_cnt_o`  out  16  count of indices skipped (invalid location); cleared on accepted `start_i`.
- `pkt_req_o`  out  1  to pkt `req_i`.
- `pkt_indx_o`  out  32  to pkt `fuse_indx_i`. Zero-extended current index.
- `pkey_loc_i`  in  64  from pkt `pkey_loc_o`. Valid the cycle after `pkt_req_o`.
- `fuse_req_o`  out  1  fuse memory read strobe.
- `fuse_addr_o`  out  32  fuse word index, equal to `pkt_indx_o`.
- `fuse_rdata_i`  in  32  fuse data. Valid the cycle after `fuse_req_o`.
- `wr_valid_o`  out  1  write request.
- `wr_addr_o`  out  64  write address, equal to the captured `pkey_loc_i`.
- `wr_data_o`  out  32  write data, equal to the captured `fuse_rdata_i`.
- `wr_ready_i`  in  1  write accepted when sampled high together with `wr_valid_o`.

## Operation
FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE: when `start_i`=1, go to REQ. On entry to REQ: index=0, `err_o`=0, `skip_cnt_o`=0.
- REQ: `pkt_req_o`=1 and `fuse_req_o`=1, both addressed with the index. Go to WAIT.
- WAIT:
  - Capture `pkey_loc_i` into the address register and `fuse_rdata_i` into the data register.
  - If `pkey_loc_i` == 64'h0000_0000_FFFF_FFFF (pkt out-of-range value), the index is invalid: set `err_o`, increment `skip_cnt_o` (saturating at 16'hFFFF), then advance.
  - Otherwise, clear the timeout counter and go to WRITE.
- WRITE:
  - Hold `wr_valid_o`=1. Keep `wr_addr_o` and `wr_data_o` stable until the handshake.
  - Handshake (`wr_valid_o` & `wr_ready_i`): advance.
  - Otherwise increment the timeout counter. If it reaches `WR_TIMEOUT` without a handshake, drop `wr_valid_o`, set `err_o`, then advance.
- Advance:
  - If index == NUM_KEYS-1, go to DONE.
  - Else index+1, go to REQ.
- DONE: `done_o`=1 for one cycle, go to IDLE. `err_o` and `skip_cnt_o` hold until the next accepted start.
- Index counter width is 16 bits. It never wraps, because the sequence terminates at NUM_KEYS-1.
- `start_i` in any state other than IDLE has no effect.
- The block never reissues a write after a timeout. The key is lost, and that is reported via `err_o` only.

## Timing
- Reset values of all outputs are 0: `busy_o`, `done_o`, `err_o`, `skip_cnt_o`, `pkt_req_o`, `pkt_indx_o`, `fuse_req_o`, `fuse_addr_o`, `wr_valid_o`, `wr_addr_o`, `wr_data_o`. FSM resets to IDLE.
- Asserting `rst_ni` low mid-sequence forces everything to reset values immediately. `wr_valid_o` may drop without a handshake. There is no resume; a new `start_i` is required.
- `pkt_req_o` and `fuse_req_o` are high exactly one cycle per index, in REQ.
- Per index with `wr_ready_i` tied high: REQ, WAIT, WRITE = 3 cycles. A skipped index takes 2 cycles.
- Full sequence with no stalls: `start_i` at cycle 0, `busy_o` from cycle 1, first `wr_valid_o` at cycle 3, `done_o` at cycle 3·NUM_KEYS+1.
- Each `wr_ready_i` stall cycle adds one cycle.
- A timeout costs exactly `WR_TIMEOUT` cycles in WRITE.
- `wr_addr_o` and `wr_data_o` are registered outputs, stable throughout WRITE.

## Test plan
- NUM_KEYS=4, `wr_ready_i`=1, pkt model returns address 0x1000+4·i, fuse returns 0xA0+i:
  - exactly 4 writes, (0x1000,0xA0)…(0x100C,0xA3);
  - `done_o` at cycle 13;
  - `err_o`=0.
- Hold `wr_ready_i` low for 5 cycles on index 1: `wr_valid_o`, `wr_addr_o` and `wr_data_o` stay stable for 6 cycles; one handshake only; `done_o` delayed by 5 cycles.
- pkt model returns 0xFFFF_FFFF for index 2: no write to that address; `skip_cnt_o`=1; `err_o`=1; `done_o` at cycle 12.
- `WR_TIMEOUT`=8, `wr_ready_i`=0 forever, NUM_KEYS=2: each index spends 8 cycles in WRITE; `err_o`=1; `done_o` asserts; no handshake occurs.
- `start_i` pulsed while busy: no restart and no extra writes. `rst_ni` low during WRITE: all outputs 0 the same cycle; a new `start_i` replays from index 0.
- Back-to-back sequences: a second start right after `done_o` clears `err_o`/`skip_cnt_o` and repeats the identical write trace.
